multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-style FSM that sequences the multi-cycle MIPS datapath: one shared memory, IR, A/B/ALUOut/MDR registers, one ALU. It supports the same instruction subset as the single-cycle decoder: R-type, lw, sw, beq, lui and j. Each instruction is stepped through fetch, decode, execute, memory and write-back. A memory ready handshake stalls the FSM on slow memory.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch if equal
OP_LUI, 6'b001111, load upper immediate
OP_J, 6'b000010, jump

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request (FETCH, MEMRD, MEMWR)
IorD  out  1  0=PC addresses memory, 1=ALUOut
IRWrite  out  1  load IR
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
MemWrite  out  1  memory write strobe
MemtoReg  out  1  register write data: 1=MDR, 0=ALUOut
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALU_op  out  3  000=add, 100=sub, 110=lui
R_type  out  1  ALU decodes the funct field
instr_done  out  1  one-cycle pulse when an instruction retires
state  out  4  current state, for debug

Behaviour:
- State register is 4 bits and updates only on the rising edge of clk.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, LUIEX=10, LUIWB=11, codes 12-15 unused.
- Reset: while rst=1, every output is 0 and state=FETCH on the next edge. Reset mid-instruction aborts the instruction with no write strobes in that cycle.
- Outputs not listed for a state are 0. All outputs are combinational from state, gated by mem_ready where noted.

FETCH:
- Drives mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PCSource=00.
- IRWrite=PCWrite=mem_ready.
- Stays in FETCH while mem_ready=0, otherwise moves to DECODE.

DECODE:
- Drives ALUSrcA=0, ALUSrcB=11, ALU_op=000 (branch target into ALUOut).
- Next state by op: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, j→JUMP, lui→LUIEX.
- Any other op goes to FETCH with instr_done=1 and acts as a NOP.

MEMADR:
- Drives ALUSrcA=1, ALUSrcB=10, ALU_op=000.
- op=lw→MEMRD, otherwise→MEMWR.

MEMRD:
- Drives mem_req=1, IorD=1.
- Holds until mem_ready=1, then goes to MEMWB.

MEMWB:
- Drives RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1.
- Next state is FETCH.

MEMWR:
- Drives mem_req=1, IorD=1, MemWrite=1 held stable across the stall.
- instr_done=mem_ready.
- Goes to FETCH when mem_ready=1.

EXEC and RWB (R-type):
- EXEC drives ALUSrcA=1, ALUSrcB=00, R_type=1, then goes to RWB.
- RWB drives RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, then goes to FETCH.

BRANCH:
- Drives ALUSrcA=1, ALUSrcB=00, ALU_op=100, PCWriteCond=1, PCSource=01, instr_done=1.
- Next state is FETCH.

JUMP:
- Drives PCWrite=1, PCSource=10, instr_done=1.
- Next state is FETCH.

LUIEX and LUIWB:
- LUIEX drives ALUSrcA=1, ALUSrcB=10, ALU_op=110, then goes to LUIWB.
- LUIWB drives RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, then goes to FETCH.

General rules:
- Unused state codes go to FETCH with all outputs 0.
- op is sampled only in DECODE and MEMADR.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Latency with mem_ready tied to 1, in cycles: lw=5, sw=4, R-type=4, lui=4, beq=3, j=3.
- Each memory stall cycle adds exactly one cycle.

Test Plan:
1. rst=1 for 2 cycles with mem_ready=1 → all outputs 0. After release: state=0, mem_req=1, IRWrite=1, PCWrite=1.
2. op=100011, mem_ready=1 → state sequence 0,1,2,3,4,0. In state 4: RegWrite=1, MemtoReg=1, instr_done=1. 5 cycles per instruction.
3. op=101011, mem_ready held 0 for 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles. instr_done=1 only in the last of them. RegWrite stays 0 throughout.
4. op=000100 → state sequence 0,1,8. In state 8: ALU_op=100, PCWriteCond=1, PCSource=01. op=000010 → state 9 with PCWrite=1, PCSource=10.
5. op=001111 → states 10 then 11, with ALU_op=110 and ALUSrcB=10 in 10 and RegWrite=1, RegDst=0 in 11. op=000000 → states 6 then 7, with R_type=1 in 6 and RegDst=1, RegWrite=1 in 7.
6. op=111111 → DECODE goes straight to FETCH with instr_done=1 and no write strobes. rst asserted in MEMRD → next state=0 and no RegWrite is issued.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut/MDR, one ALU).
// Each instruction is sequenced through fetch, decode, execute, memory and write-back.
// The mem_ready handshake stalls FETCH, MEMRD and MEMWR on slow memory.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   op              IR[31:26], sampled in DECODE and MEMADR only
//   mem_ready       memory access completes this cycle
//   mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, MemWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_op, R_type
//                   datapath controls, decoded from the current state
//   instr_done      one-cycle pulse when an instruction retires
//   state           current state code, for debug
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_op,
  output logic       R_type,
  output logic       instr_done,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_LUIEX  = 4'd10,
    S_LUIWB  = 4'd11
  } state_t;

  state_t state_q;

  assign state = state_q;

  // State register with next-state selection
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_LUI:       state_q <= S_LUIEX;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_RWB;
        S_RWB:    state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_LUIEX:  state_q <= S_LUIWB;
        S_LUIWB:  state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Moore decode; rst forces every strobe low so an aborted instruction writes nothing
  always_comb begin
    mem_req     = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_op      = 3'b000;
    R_type      = 1'b0;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          // Unsupported opcodes retire here as a NOP
          case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_LUI: instr_done = 1'b0;
            default:                                      instr_done = 1'b1;
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          // MemWrite held through the stall; retire on the completing cycle
          mem_req    = 1'b1;
          IorD       = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          R_type  = 1'b1;
        end
        S_RWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALU_op      = 3'b100;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_LUIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALU_op  = 3'b110;
        end
        S_LUIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver applies one input vector per
// cycle and queues the hand-computed output vector; a monitor compares at negedge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, IorD, IRWrite, PCWrite, PCWriteCond, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, R_type, instr_done;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALU_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .PCSource(PCSource), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_op(ALU_op), .R_type(R_type),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  // {state, mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, MemWrite,
  //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_op, R_type, instr_done}
  logic [22:0] obs;
  assign obs = {state, mem_req, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_op,
                R_type, instr_done};

  //                               st     mrq   iord  irw   pcw   pwc   pcs    mw    m2r   rd    rw    sa    sb     aluop   rt    done
  localparam logic [22:0] E_RST0   = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_RST3   = {4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_FETCH  = {4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_FSTALL = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_DEC    = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_DECNOP = {4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 1'b0, 1'b1};
  localparam logic [22:0] E_MADR   = {4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_MRD    = {4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_MWB    = {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1};
  localparam logic [22:0] E_MWRS   = {4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0};
  localparam logic [22:0] E_MWRD   = {4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1};
  localparam logic [22:0] E_EXEC   = {4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 1'b0};
  localparam logic [22:0] E_RWB    = {4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1};
  localparam logic [22:0] E_BR     = {4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1};
  localparam logic [22:0] E_JMP    = {4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1};
  localparam logic [22:0] E_LUIEX  = {4'd10,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b110, 1'b0, 1'b0};
  localparam logic [22:0] E_LUIWB  = {4'd11,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] OP_GRB = 6'b101010;

  typedef struct {
    logic [22:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  // Apply inputs for the coming cycle and queue the expected outputs for it
  task automatic step(input logic r, input logic mr, input logic [5:0] o,
                      input logic [22:0] e, input string n);
    exp_t item;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = mr;
    op        = o;
    item.exp  = e;
    item.name = n;
    sb_q.push_back(item);
  endtask

  // Monitor: compare at the falling edge, away from state updates
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t item;
        item = sb_q.pop_front();
        checks++;
        if (obs !== item.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", item.name, obs, item.exp);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    op        = OP_GRB;
    // First reset cycle: state not yet defined, only the second is checked
    step(1'b1, 1'b1, OP_GRB, E_RST0,   "reset");

    // lw, no stalls: 0,1,2,3,4
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "lw.fetch");
    step(1'b0, 1'b0, OP_LW,  E_DEC,    "lw.decode");
    step(1'b0, 1'b0, OP_LW,  E_MADR,   "lw.memadr");
    step(1'b0, 1'b1, OP_GRB, E_MRD,    "lw.memrd");
    step(1'b0, 1'b0, OP_GRB, E_MWB,    "lw.memwb");

    // sw with one fetch stall and three MEMWR stalls
    step(1'b0, 1'b0, OP_GRB, E_FSTALL, "sw.fetch_stall");
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "sw.fetch");
    step(1'b0, 1'b1, OP_SW,  E_DEC,    "sw.decode");
    step(1'b0, 1'b1, OP_SW,  E_MADR,   "sw.memadr");
    step(1'b0, 1'b0, OP_GRB, E_MWRS,   "sw.memwr_stall1");
    step(1'b0, 1'b0, OP_GRB, E_MWRS,   "sw.memwr_stall2");
    step(1'b0, 1'b0, OP_GRB, E_MWRS,   "sw.memwr_stall3");
    step(1'b0, 1'b1, OP_GRB, E_MWRD,   "sw.memwr_done");

    // lw with a MEMRD stall
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "lw2.fetch");
    step(1'b0, 1'b1, OP_LW,  E_DEC,    "lw2.decode");
    step(1'b0, 1'b1, OP_LW,  E_MADR,   "lw2.memadr");
    step(1'b0, 1'b0, OP_GRB, E_MRD,    "lw2.memrd_stall");
    step(1'b0, 1'b1, OP_GRB, E_MRD,    "lw2.memrd");
    step(1'b0, 1'b1, OP_GRB, E_MWB,    "lw2.memwb");

    // beq
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "beq.fetch");
    step(1'b0, 1'b1, OP_BEQ, E_DEC,    "beq.decode");
    step(1'b0, 1'b0, OP_GRB, E_BR,     "beq.branch");

    // j
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "j.fetch");
    step(1'b0, 1'b1, OP_J,   E_DEC,    "j.decode");
    step(1'b0, 1'b0, OP_GRB, E_JMP,    "j.jump");

    // lui
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "lui.fetch");
    step(1'b0, 1'b1, OP_LUI, E_DEC,    "lui.decode");
    step(1'b0, 1'b0, OP_GRB, E_LUIEX,  "lui.ex");
    step(1'b0, 1'b0, OP_GRB, E_LUIWB,  "lui.wb");

    // R-type
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "r.fetch");
    step(1'b0, 1'b1, OP_R,   E_DEC,    "r.decode");
    step(1'b0, 1'b0, OP_GRB, E_EXEC,   "r.exec");
    step(1'b0, 1'b0, OP_GRB, E_RWB,    "r.rwb");

    // Unknown opcode retires from DECODE as a NOP
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "nop.fetch");
    step(1'b0, 1'b1, OP_BAD, E_DECNOP, "nop.decode");

    // Reset asserted in MEMRD: strobes suppressed, back to FETCH
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "abort.fetch");
    step(1'b0, 1'b1, OP_LW,  E_DEC,    "abort.decode");
    step(1'b0, 1'b1, OP_LW,  E_MADR,   "abort.memadr");
    step(1'b1, 1'b1, OP_GRB, E_RST3,   "abort.memrd_rst");
    step(1'b0, 1'b1, OP_GRB, E_FETCH,  "abort.refetch");
    step(1'b0, 1'b1, OP_LW,  E_DEC,    "abort.redecode");

    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
